dram_arbiter: RTL and testbench
===============================

# dram_arbiter

Two-requester arbiter and access sequencer for the shared single-port DRAM. Sits between the DRAM and two masters: requester 0 (processor) and requester 1 (image loader/unloader). Grants one transaction at a time, round-robin on contention, holds the DRAM strobe until completion, and forces completion with an error on timeout.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 8, data width
- TIMEOUT, 255, max cycles in WAIT before forced completion (≥2)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- req_rd[1:0]  in  2  read request, one bit per requester; level, held until done
- req_wr[1:0]  in  2  write request, one bit per requester; level, held until done
- req_addr0, req_addr1  in  ADDR_W  per-requester address
- req_wdata0, req_wdata1  in  DATA_W  per-requester write data
- req_rdata  out  DATA_W  read data of last completed read (shared)
- req_done[1:0]  out  2  one-cycle completion pulse to the granted requester
- req_err  out  1  valid with req_done; 1 = timeout
- read  out  1  DRAM read strobe
- write  out  1  DRAM write strobe
- addr  out  ADDR_W  DRAM address
- din  out  DATA_W  DRAM write data
- dout  in  DATA_W  DRAM read data
- rd_done  in  1  DRAM read complete
- wr_done  in  1  DRAM write complete

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: requester i is active if req_rd[i] or req_wr[i]. One active → grant it. Both active → grant the one not granted last (last_grant register, reset to 1, so requester 0 wins first contention). Register grant, op (write if req_wr, else read), addr, din; go to WAIT.
- Same requester with req_rd and req_wr both high: write is performed, read is dropped; requester receives one done.
- WAIT: read=1 (read op) or write=1 (write op), addr/din stable. On the matching done input (rd_done for read, wr_done for write; the other is ignored) → DONE, strobe drops, read op captures dout into req_rdata, req_err=0.
- Timeout: counter cleared on entry to WAIT, increments each WAIT cycle; at count TIMEOUT-1 with no done → DONE, req_err=1, req_rdata=0, strobe drops.
- DONE: req_done[grant]=1 for exactly one cycle; last_grant←grant; requests ignored; next state IDLE.
- Requester must drop its request by the edge ending the req_done cycle; a request still high in IDLE is treated as a new transaction.
- Non-granted request held during a transaction waits; it is served next (round-robin guarantees ≤1 intervening transaction).

## Timing
- All outputs registered. Reset values: read=0, write=0, addr=0, din=0, req_rdata=0, req_done=0, req_err=0; state IDLE, last_grant=1, counter 0.
- Request sampled high at edge k → strobe, addr, din valid after edge k.
- Matching done sampled at edge m → strobe low and req_done/req_err/req_rdata valid after edge m; IDLE after m+1.
- Minimum req-to-done: req_done high in cycle following edge k+1 (DRAM done at first WAIT cycle). Back-to-back grants separated by ≥1 IDLE cycle.
- Timeout: req_done asserted TIMEOUT cycles after entering WAIT.
- rd_done/wr_done outside WAIT: ignored.
- Reset asserted mid-transaction: immediately IDLE, strobes low, no req_done for the aborted transaction.

## Structure
- Package dram_arb_pkg: state enum (IDLE, WAIT, DONE), op encoding (OP_RD, OP_WR), default widths.
- Sub-module timeout_counter: clear, enable, terminal-count output at TIMEOUT-1; width $clog2(TIMEOUT).
- Top holds FSM, round-robin pick, output registers; target 150–250 lines.

## Test plan
- Single read: req_rd[0]=1, addr0=16'h0010, DRAM returns 8'hA5 with rd_done 3 cycles later → read high 3 cycles, req_done=2'b01 one cycle, req_rdata=8'hA5, req_err=0.
- Single write: req_wr[1]=1, addr1=16'h1234, wdata1=8'h3C, wr_done after 1 cycle → write=1, addr=16'h1234, din=8'h3C, req_done=2'b10.
- Contention: both request reads from reset → requester 0 served first, then 1; repeat both held → order alternates 0,1,0,1.
- Timeout, TIMEOUT=8: read with no rd_done → req_done after 8 WAIT cycles, req_err=1, req_rdata=0, read drops.
- Illegal combo + stray done: req_rd[0]=req_wr[0]=1 → only write issued, one done; wr_done pulse in IDLE → no effect.
- Reset mid-WAIT: reset=0 during read → read=0 asynchronously, no req_done; after release, held request re-granted.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// rtl/dram_arb_pkg.sv - shared constants and helpers for the two-requester DRAM arbiter
package dram_arb_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 8;
    localparam int TIMEOUT_DEF = 255;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // Only meaningful when at least one requester is active; contention goes to the one not served last.
    function automatic logic rr_pick(input logic [1:0] active, input logic last_grant);
        if (active == 2'b11) begin
            return ~last_grant;
        end
        return active[1];
    endfunction

endpackage

// File: rtl/timeout_counter.sv
// rtl/timeout_counter.sv - WAIT-cycle counter with terminal count at TIMEOUT-1
module timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !tc) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - round-robin arbiter and access sequencer for the shared single-port DRAM
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_rd,
    input  logic [1:0]        req_wr,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [DATA_W-1:0] req_rdata,
    output logic [1:0]        req_done,
    output logic              req_err,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout,
    input  logic              rd_done,
    input  logic              wr_done
);

    logic [1:0] state;
    logic       last_grant;
    logic       grant;
    logic       op;
    logic [1:0] active;
    logic       pick;
    logic       done_hit;
    logic       tmo_tc;

    assign active   = req_rd | req_wr;
    assign pick     = rr_pick(active, last_grant);
    // Only the done line matching the issued op counts; the other is ignored.
    assign done_hit = (op == OP_WR) ? wr_done : rd_done;

    timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != S_WAIT),
        .enable (state == S_WAIT),
        .tc     (tmo_tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            op         <= OP_RD;
            read       <= 1'b0;
            write      <= 1'b0;
            addr       <= '0;
            din        <= '0;
            req_rdata  <= '0;
            req_done   <= '0;
            req_err    <= 1'b0;
        end else begin
            req_done <= '0;
            req_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|active) begin
                        // A write wins over a read raised by the same requester.
                        grant <= pick;
                        op    <= req_wr[pick] ? OP_WR : OP_RD;
                        read  <= ~req_wr[pick];
                        write <= req_wr[pick];
                        addr  <= pick ? req_addr1 : req_addr0;
                        din   <= pick ? req_wdata1 : req_wdata0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (done_hit || tmo_tc) begin
                        read     <= 1'b0;
                        write    <= 1'b0;
                        req_done <= grant ? 2'b10 : 2'b01;
                        req_err  <= ~done_hit;
                        if (!done_hit) begin
                            req_rdata <= '0;
                        end else if (op == OP_RD) begin
                            req_rdata <= dout;
                        end
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    last_grant <= grant;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - self-checking bench for dram_arbiter against a transaction-level model
module tb_dram_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 8;

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic [1:0]    req_rd     = '0;
    logic [1:0]    req_wr     = '0;
    logic [AW-1:0] req_addr0  = '0;
    logic [AW-1:0] req_addr1  = '0;
    logic [DW-1:0] req_wdata0 = '0;
    logic [DW-1:0] req_wdata1 = '0;
    logic [DW-1:0] dout       = '0;
    logic          rd_done    = 1'b0;
    logic          wr_done    = 1'b0;
    logic [DW-1:0] req_rdata;
    logic [1:0]    req_done;
    logic          req_err;
    logic          read;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_rd     (req_rd),
        .req_wr     (req_wr),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .req_rdata  (req_rdata),
        .req_done   (req_done),
        .req_err    (req_err),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .din        (din),
        .dout       (dout),
        .rd_done    (rd_done),
        .wr_done    (wr_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one transaction in flight, counted in WAIT cycles.
    bit            m_busy;
    int            m_g;
    bit            m_wr;
    int            m_elapsed;
    logic [1:0]    m_done;
    bit            m_err;
    logic [DW-1:0] m_rdata;
    int            m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;
    bit            m_a0;
    bit            m_a1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_g = 0; m_wr = 0; m_elapsed = 0; m_done = '0; m_err = 0;
            m_rdata = '0; m_last = 1; m_addr = '0; m_din = '0;
        end else if (m_done != 2'b00) begin
            m_done = '0;
            m_err  = 0;
        end else if (m_busy) begin
            m_elapsed++;
            if (m_wr ? wr_done : rd_done) begin
                m_busy = 0;
                m_done = (m_g == 1) ? 2'b10 : 2'b01;
                m_err  = 0;
                if (!m_wr) m_rdata = dout;
                m_last = m_g;
            end else if (m_elapsed == TO) begin
                m_busy  = 0;
                m_done  = (m_g == 1) ? 2'b10 : 2'b01;
                m_err   = 1;
                m_rdata = '0;
                m_last  = m_g;
            end
        end else begin
            m_a0 = req_rd[0] | req_wr[0];
            m_a1 = req_rd[1] | req_wr[1];
            if (m_a0 || m_a1) begin
                m_g       = (m_a0 && m_a1) ? 1 - m_last : (m_a0 ? 0 : 1);
                m_wr      = req_wr[m_g];
                m_busy    = 1;
                m_elapsed = 0;
                m_addr    = (m_g == 1) ? req_addr1 : req_addr0;
                m_din     = (m_g == 1) ? req_wdata1 : req_wdata0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("read", read, m_busy && !m_wr);
            chk("write", write, m_busy && m_wr);
            chk("req_done", req_done, m_done);
            chk("req_err", req_err, m_err);
            chk("req_rdata", req_rdata, m_rdata);
            if (m_busy) begin
                chk("addr", addr, m_addr);
                chk("din", din, m_din);
            end
        end
    end

    // Raises one request, plays the DRAM with the matching done after 'delay' strobe cycles
    // (0 = never), and drives the non-matching done line meanwhile.
    task automatic do_txn(input int i, input bit rd, input bit wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int delay, input logic [DW-1:0] rdv,
                          output int rd_cyc, output int wr_cyc,
                          output logic [AW-1:0] seen_a, output logic [DW-1:0] seen_d,
                          output logic [1:0] done_v, output logic err_v,
                          output logic [DW-1:0] rdata_v);
        int cyc = 0;
        bit got = 0;
        rd_cyc = 0; wr_cyc = 0; seen_a = 'x; seen_d = 'x; done_v = 'x; err_v = 'x; rdata_v = 'x;
        if (i == 0) begin req_addr0 = a; req_wdata0 = d; end
        else        begin req_addr1 = a; req_wdata1 = d; end
        req_rd[i] = rd;
        req_wr[i] = wr;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            rd_done = 0;
            wr_done = 0;
            if (req_done != 2'b00) begin
                got = 1; done_v = req_done; err_v = req_err; rdata_v = req_rdata;
                req_rd[i] = 0; req_wr[i] = 0;
            end else if (read || write) begin
                cyc++;
                if (read)  rd_cyc++;
                if (write) wr_cyc++;
                seen_a = addr;
                seen_d = din;
                if (cyc == delay) begin
                    if (write) wr_done = 1;
                    else begin rd_done = 1; dout = rdv; end
                end else begin
                    if (write) rd_done = 1;
                    else       wr_done = 1;
                end
            end
        end
        chk("txn_bound", got, 1);
    endtask

    int            rc, wc, n, reraise, w, seen, ndone;
    int            order[4];
    logic [AW-1:0] sa;
    logic [DW-1:0] sd, rdv;
    logic [1:0]    dv, kind;
    logic          ev;
    bit            pend[2];

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_read", read, 0);
        chk("rst_write", write, 0);
        chk("rst_addr", addr, 0);
        chk("rst_din", din, 0);
        chk("rst_rdata", req_rdata, 0);
        chk("rst_done", req_done, 0);
        chk("rst_err", req_err, 0);
        cmp_en = 1;
        @(negedge clk);
        reset = 1;
        @(negedge clk);

        do_txn(0, 1, 0, 16'h0010, 8'h00, 3, 8'hA5, rc, wc, sa, sd, dv, ev, rdv);
        chk("rd_cycles", rc, 3);
        chk("rd_no_write", wc, 0);
        chk("rd_addr", sa, 16'h0010);
        chk("rd_done", dv, 2'b01);
        chk("rd_err", ev, 0);
        chk("rd_data", rdv, 8'hA5);

        do_txn(0, 1, 0, 16'h0020, 8'h00, 0, 8'h00, rc, wc, sa, sd, dv, ev, rdv);
        chk("tmo_cycles", rc, TO);
        chk("tmo_done", dv, 2'b01);
        chk("tmo_err", ev, 1);
        chk("tmo_rdata", rdv, 0);

        do_txn(1, 0, 1, 16'h1234, 8'h3C, 1, 8'h00, rc, wc, sa, sd, dv, ev, rdv);
        chk("wr_cycles", wc, 1);
        chk("wr_no_read", rc, 0);
        chk("wr_addr", sa, 16'h1234);
        chk("wr_din", sd, 8'h3C);
        chk("wr_done", dv, 2'b10);
        chk("wr_err", ev, 0);

        do_txn(0, 1, 1, 16'h55AA, 8'h77, 2, 8'h00, rc, wc, sa, sd, dv, ev, rdv);
        chk("combo_write", wc, 2);
        chk("combo_no_read", rc, 0);
        chk("combo_done", dv, 2'b01);
        seen = 0;
        rd_done = 1;
        wr_done = 1;
        repeat (3) begin
            @(negedge clk);
            if (req_done != 2'b00 || read || write) seen++;
        end
        rd_done = 0;
        wr_done = 0;
        chk("combo_single_done_and_stray_ignored", seen, 0);

        // Contention from a fresh reset: requester 0 first, then strict alternation.
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        reset = 1;
        req_addr0 = 16'h0100;
        req_addr1 = 16'h0200;
        req_rd = 2'b11;
        n = 0;
        reraise = -1;
        for (int t = 0; t < 80 && n < 4; t++) begin
            @(negedge clk);
            rd_done = 0;
            if (reraise >= 0) begin req_rd[reraise] = 1; reraise = -1; end
            if (req_done != 2'b00) begin
                w = req_done[1] ? 1 : 0;
                order[n] = w;
                n++;
                req_rd[w] = 0;
                reraise = w;
            end else if (read) begin
                rd_done = 1;
            end
        end
        req_rd = 2'b00;
        rd_done = 0;
        chk("rr_count", n, 4);
        chk("rr_0", order[0], 0);
        chk("rr_1", order[1], 1);
        chk("rr_2", order[2], 0);
        chk("rr_3", order[3], 1);

        // Reset in the middle of a read: strobe drops at once, the held request is served afresh.
        @(negedge clk);
        req_addr1 = 16'h0BEE;
        req_rd[1] = 1;
        seen = 0;
        for (int t = 0; t < 20 && seen < 2; t++) begin
            @(negedge clk);
            if (read) seen++;
        end
        chk("abort_read_seen", seen, 2);
        #2 reset = 0;
        #1;
        chk("abort_read_low", read, 0);
        chk("abort_no_done", req_done, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        do_txn(1, 1, 0, 16'h0BEE, 8'h00, 1, 8'h5A, rc, wc, sa, sd, dv, ev, rdv);
        chk("regrant_done", dv, 2'b10);
        chk("regrant_cycles", rc, 1);
        chk("regrant_data", rdv, 8'h5A);

        // Random traffic: requesters hold until served, DRAM answers at random or not at all.
        pend[0] = 0;
        pend[1] = 0;
        ndone = 0;
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            dout    = DW'($urandom);
            rd_done = ($urandom_range(0, 3) == 0);
            wr_done = ($urandom_range(0, 3) == 0);
            if (req_done != 2'b00) ndone++;
            for (int i = 0; i < 2; i++) begin
                if (pend[i] && req_done[i]) begin
                    pend[i] = 0;
                    req_rd[i] = 0;
                    req_wr[i] = 0;
                end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    kind = 2'($urandom_range(1, 3));
                    req_rd[i] = kind[0];
                    req_wr[i] = kind[1];
                    if (i == 0) begin req_addr0 = AW'($urandom); req_wdata0 = DW'($urandom); end
                    else        begin req_addr1 = AW'($urandom); req_wdata1 = DW'($urandom); end
                    pend[i] = 1;
                end
            end
        end
        req_rd = 2'b00;
        req_wr = 2'b00;
        rd_done = 0;
        wr_done = 0;
        chk("random_progress", ndone > 50, 1);
        repeat (TO + 4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
